// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: tracks fetch predictions through D/E, resolves them in E,
// drives table updates, redirects and a fixed-length flush. Optional perf counters: BRU_PERF_EN.
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_valid,
  input  logic [31:0]      f_pc,
  input  logic             f_pred_taken,
  input  logic [31:0]      f_pred_pc,
  input  logic             stall,
  input  logic             e_is_branch,
  input  logic             e_is_jump,
  input  logic             e_taken,
  input  logic [31:0]      e_target,
  output logic             upd_bt,
  output logic [31:0]      pc_e,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  typedef enum logic {IDLE, FLUSH} state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } slot_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  slot_t       d_q, d_d, e_q, e_d, f_slot;
  state_e      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] actual_next;
  logic        resolve, mispredict, upd;

  logic        upd_bt_q, upd_bt_d, upd_taken_q, upd_taken_d, redir_q, redir_d;
  logic [31:0] pc_e_q, pc_e_d, upd_target_q, upd_target_d, redir_pc_q, redir_pc_d;

  // Direction is implied by pred_pc, so the stored pred_taken bit has no consumer here.
  logic unused_pred_taken;
  assign unused_pred_taken = e_q.pred_taken;

  always_comb begin
    f_slot      = '{valid: f_valid, pc: f_pc, pred_taken: f_pred_taken, pred_pc: f_pred_pc};
    actual_next = (e_is_jump | (e_is_branch & e_taken)) ? e_target : e_q.pc + 32'd4;
    resolve     = e_q.valid & ~stall & (state_q == IDLE);
    mispredict  = resolve & (actual_next != e_q.pred_pc);
    upd         = resolve & (e_is_branch | e_is_jump);

    d_d     = d_q;
    e_d     = e_q;
    state_d = state_q;
    fcnt_d  = fcnt_q;

    if (state_q == FLUSH) begin
      // Flush wins over stall: both stages keep moving, carrying only bubbles.
      d_d       = f_slot;
      d_d.valid = 1'b0;
      e_d       = d_q;
      e_d.valid = 1'b0;
      if (fcnt_q == 3'd0) state_d = IDLE;
      else                fcnt_d  = fcnt_q - 3'd1;
    end else if (!stall) begin
      d_d = f_slot;
      e_d = d_q;
      if (mispredict) begin
        d_d.valid = 1'b0;
        e_d.valid = 1'b0;
        state_d   = FLUSH;
        fcnt_d    = FLUSH_LAST;
      end
    end

    upd_bt_d     = upd;
    pc_e_d       = upd ? e_q.pc : 32'd0;
    upd_taken_d  = upd & (e_is_jump | e_taken);
    upd_target_d = upd ? e_target : 32'd0;
    redir_d      = mispredict;
    redir_pc_d   = mispredict ? actual_next : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q          <= '0;
      e_q          <= '0;
      state_q      <= IDLE;
      fcnt_q       <= 3'd0;
      upd_bt_q     <= 1'b0;
      pc_e_q       <= 32'd0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= 32'd0;
      redir_q      <= 1'b0;
      redir_pc_q   <= 32'd0;
    end else begin
      d_q          <= d_d;
      e_q          <= e_d;
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      upd_bt_q     <= upd_bt_d;
      pc_e_q       <= pc_e_d;
      upd_taken_q  <= upd_taken_d;
      upd_target_q <= upd_target_d;
      redir_q      <= redir_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  assign upd_bt         = upd_bt_q;
  assign pc_e           = pc_e_q;
  assign upd_taken      = upd_taken_q;
  assign upd_target     = upd_target_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;
  assign flush          = (state_q == FLUSH);

`ifdef BRU_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  // Counters sample the registered pulses and stick at all-ones.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_bt_q && br_cnt_q != CNT_MAX)  br_cnt_d  = br_cnt_q + CNT_W'(1);
    if (redir_q && mis_cnt_q != CNT_MAX)  mis_cnt_d = mis_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule
